// File: rtl/axis_red_pitaya_adc_nch_pkg.sv
// Shared constants, lane/slice helpers and width checks for the N-channel ADC decimator.
package axis_red_pitaya_adc_nch_pkg;

   localparam int DEF_ADC_DATA_WIDTH   = 32'd14;
   localparam int DEF_AXIS_TDATA_WIDTH = 32'd32;
   localparam int DEF_NUM_CH           = 32'd2;
   localparam int DEF_DECIM_WIDTH      = 32'd16;
   localparam int OVR_CNT_WIDTH        = 32'd32;

   // A lane must hold a full sample plus one bit so that negating the most negative code cannot wrap.
   localparam int SIGN_HEADROOM = 32'd1;
   localparam int MIN_NUM_CH    = 32'd1;
   localparam int MAX_NUM_CH    = 32'd8;

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

   function automatic bit width_ok(input int adc_w, input int axis_w);
      return axis_w >= (adc_w + SIGN_HEADROOM);
   endfunction

   function automatic bit num_ch_ok(input int n);
      return (n >= MIN_NUM_CH) && (n <= MAX_NUM_CH);
   endfunction

endpackage

// File: rtl/axis_red_pitaya_adc_nch_if.sv
// AXI-Stream master/slave bundle carrying the packed per-channel sums.
interface axis_red_pitaya_adc_nch_if
   import axis_red_pitaya_adc_nch_pkg::*;
#(
   parameter int TDATA_WIDTH = DEF_NUM_CH * DEF_AXIS_TDATA_WIDTH
);
   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_red_pitaya_adc_nch_acc.sv
// One channel: offset-binary to two's complement, optional negate, and block accumulation.
module axis_red_pitaya_adc_nch_acc
   import axis_red_pitaya_adc_nch_pkg::*;
#(
   parameter int ADC_DATA_WIDTH   = DEF_ADC_DATA_WIDTH,
   parameter int AXIS_TDATA_WIDTH = DEF_AXIS_TDATA_WIDTH
)(
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        sample_vld,
   input  logic                        last,
   input  logic                        negate,
   input  logic [ADC_DATA_WIDTH-1:0]   sample,
   output logic [AXIS_TDATA_WIDTH-1:0] result
);
   localparam int EXT_W = AXIS_TDATA_WIDTH - ADC_DATA_WIDTH;

   logic [ADC_DATA_WIDTH-1:0]   tc_s;
   logic [AXIS_TDATA_WIDTH-1:0] sext_s;
   logic [AXIS_TDATA_WIDTH-1:0] conv_s;
   logic [AXIS_TDATA_WIDTH-1:0] acc_r;

   // Convert the sample and form the running sum including it
   always_comb begin
      tc_s   = {~sample[ADC_DATA_WIDTH-1], sample[ADC_DATA_WIDTH-2:0]};
      sext_s = {{EXT_W{tc_s[ADC_DATA_WIDTH-1]}}, tc_s};
      conv_s = negate ? ({AXIS_TDATA_WIDTH{1'b0}} - sext_s) : sext_s;
      result = acc_r + conv_s;
   end

   // Accumulator restarts from zero on the edge that emits a result
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         acc_r <= '0;
      end else if (sample_vld) begin
         acc_r <= last ? {AXIS_TDATA_WIDTH{1'b0}} : result;
      end
   end
endmodule

// File: rtl/axis_red_pitaya_adc_nch.sv
// N-channel ADC block-sum decimator with AXI-Stream output and sticky overrun status.
// Optional macro ADC_OVERRUN_CNT_EN adds the 32-bit saturating sts_overrun_cnt port.
module axis_red_pitaya_adc_nch
   import axis_red_pitaya_adc_nch_pkg::*;
#(
   parameter int ADC_DATA_WIDTH   = DEF_ADC_DATA_WIDTH,
   parameter int AXIS_TDATA_WIDTH = DEF_AXIS_TDATA_WIDTH,
   parameter int NUM_CH           = DEF_NUM_CH,
   parameter int DECIM_WIDTH      = DEF_DECIM_WIDTH
)(
   input  logic                               aclk,
   input  logic                               aresetn,
   output logic                               adc_csn,
   input  logic [NUM_CH*ADC_DATA_WIDTH-1:0]   adc_dat,
   input  logic [DECIM_WIDTH-1:0]             cfg_decim,
   input  logic [NUM_CH-1:0]                  cfg_negate,
   input  logic                               cfg_ovr_clr,
   axis_red_pitaya_adc_nch_if.master          m_axis,
   output logic                               sts_overrun
`ifdef ADC_OVERRUN_CNT_EN
   ,output logic [OVR_CNT_WIDTH-1:0]          sts_overrun_cnt
`endif
);
   localparam logic [DECIM_WIDTH-1:0] DEC_ONE = DECIM_WIDTH'(1);

   generate
      if (!width_ok(ADC_DATA_WIDTH, AXIS_TDATA_WIDTH)) begin : g_bad_width
         $error("AXIS_TDATA_WIDTH must be at least ADC_DATA_WIDTH+1");
      end
      if (!num_ch_ok(NUM_CH)) begin : g_bad_num_ch
         $error("NUM_CH must be in 1..8");
      end
   endgenerate

   logic [NUM_CH*ADC_DATA_WIDTH-1:0]   adc_r;
   logic                               s1_vld_r;
   logic [DECIM_WIDTH-1:0]             cnt_r;
   logic [DECIM_WIDTH-1:0]             r_lat_r;
   logic [DECIM_WIDTH-1:0]             r_new_s;
   logic [DECIM_WIDTH-1:0]             r_eff_s;
   logic                               last_s;
   logic                               result_vld_s;
   logic                               load_s;
   logic                               drop_s;
   logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] result_s;
   logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] tdata_r;
   logic                               tvalid_r;
   logic                               ovr_r;

   assign adc_csn       = 1'b1;
   assign m_axis.tvalid = tvalid_r;
   assign m_axis.tdata  = tdata_r;
   assign sts_overrun   = ovr_r;

   // Input register; the valid flag keeps the reset value out of the first block
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         adc_r    <= '0;
         s1_vld_r <= 1'b0;
      end else begin
         adc_r    <= adc_dat;
         s1_vld_r <= 1'b1;
      end
   end

   // At block start the live ratio applies, so a new cfg_decim takes effect without a one-block lag
   always_comb begin
      r_new_s      = (cfg_decim == {DECIM_WIDTH{1'b0}}) ? DEC_ONE : cfg_decim;
      r_eff_s      = (cnt_r == {DECIM_WIDTH{1'b0}}) ? r_new_s : r_lat_r;
      last_s       = (cnt_r == (r_eff_s - DEC_ONE));
      result_vld_s = s1_vld_r & last_s;
      load_s       = result_vld_s & (~tvalid_r | m_axis.tready);
      drop_s       = result_vld_s & ~load_s;
   end

   // Shared sample counter and ratio latched at block start
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         cnt_r   <= '0;
         r_lat_r <= '0;
      end else begin
         if (cnt_r == {DECIM_WIDTH{1'b0}}) begin
            r_lat_r <= r_new_s;
         end
         if (s1_vld_r) begin
            cnt_r <= last_s ? {DECIM_WIDTH{1'b0}} : (cnt_r + DEC_ONE);
         end
      end
   end

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         axis_red_pitaya_adc_nch_acc #(
            .ADC_DATA_WIDTH   (ADC_DATA_WIDTH),
            .AXIS_TDATA_WIDTH (AXIS_TDATA_WIDTH)
         ) u_acc (
            .aclk       (aclk),
            .aresetn    (aresetn),
            .sample_vld (s1_vld_r),
            .last       (last_s),
            .negate     (cfg_negate[c]),
            .sample     (adc_r[lane_lo(c, ADC_DATA_WIDTH) +: ADC_DATA_WIDTH]),
            .result     (result_s[lane_lo(c, AXIS_TDATA_WIDTH) +: AXIS_TDATA_WIDTH])
         );
      end
   endgenerate

   // Output register: a new result wins over the handshake clearing tvalid
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         tdata_r  <= '0;
         tvalid_r <= 1'b0;
      end else if (load_s) begin
         tdata_r  <= result_s;
         tvalid_r <= 1'b1;
      end else if (tvalid_r && m_axis.tready) begin
         tvalid_r <= 1'b0;
      end
   end

   // Sticky overrun; a drop on the clearing edge keeps it set
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ovr_r <= 1'b0;
      end else if (drop_s) begin
         ovr_r <= 1'b1;
      end else if (cfg_ovr_clr) begin
         ovr_r <= 1'b0;
      end
   end

`ifdef ADC_OVERRUN_CNT_EN
   logic [OVR_CNT_WIDTH-1:0] ovr_cnt_r;
   assign sts_overrun_cnt = ovr_cnt_r;

   // Saturating drop counter; clear and drop together leave a count of one
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ovr_cnt_r <= '0;
      end else if (cfg_ovr_clr) begin
         ovr_cnt_r <= drop_s ? OVR_CNT_WIDTH'(1) : OVR_CNT_WIDTH'(0);
      end else if (drop_s && (ovr_cnt_r != {OVR_CNT_WIDTH{1'b1}})) begin
         ovr_cnt_r <= ovr_cnt_r + OVR_CNT_WIDTH'(1);
      end
   end
`endif

endmodule
